btb_update_ctrl: RTL and testbench

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_pkg.sv | 23 ++
 rtl/btb_upd_fifo.sv | 63 ++++++
 rtl/btb_update_ctrl.sv | 141 ++++++++++++++
 tb/tb_btb_update_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared defaults, state encoding and counter type for the BTB update path
package btb_pkg;

  localparam int IDX_W_DEF   = 6;
  localparam int TAG_W_DEF   = 6;
  localparam int BTB_ENTRIES = 1 << IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  typedef logic [1:0] ctr_t;

  // Two-bit saturating step: up on taken, down on not-taken, clamped to 0..3
  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    else       return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - synchronous update queue with registered full/empty and sync clear
module btb_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + 1'b1;
    if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  // Storage array; no reset needed since empty masks stale data
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and registered status flags; clear drops every queued entry
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB update controller: queued updates, 2-bit counters, flush sweep
// Optional BTB_UPDATE_STATS_EN adds stat_upd/stat_commit saturating counters.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_hash,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [31:0]      upd_target,
  input  logic             upd_taken,
  input  logic             flush,
  input  logic [IDX_W-1:0] hash_r,
  input  logic             found_raw,
  output logic             found,
  output logic [IDX_W-1:0] hash_w,
  output logic [TAG_W-1:0] tag_w,
  output logic [31:0]      dest_w,
  output logic             commit
`ifdef BTB_UPDATE_STATS_EN
  ,
  output logic [15:0]      stat_upd,
  output logic [15:0]      stat_commit
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int REC_W   = IDX_W + TAG_W + 32 + 1;

  state_t             state, state_nxt;
  ctr_t               cnt [ENTRIES];
  ctr_t               ctr_new;
  logic [ENTRIES-1:0] valid;
  logic [IDX_W-1:0]   w_hash, sweep_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [31:0]        w_target;
  logic               w_taken;
  logic               push, pop, fifo_full, fifo_empty;
  logic [REC_W-1:0]   fifo_rdata;

  // Flush wins over a simultaneous offer; FLUSH itself also deasserts ready
  assign upd_ready = ~fifo_full & (state != FLUSH);
  assign push      = upd_valid & upd_ready & ~flush;
  assign found     = found_raw & valid[hash_r] & (state != FLUSH);
  assign hash_w    = w_hash;
  assign tag_w     = w_tag;
  assign dest_w    = w_target;

  btb_upd_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (flush),
    .push  (push),
    .wdata ({upd_hash, upd_tag, upd_target, upd_taken}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, pop and commit; a flush cancels whatever this cycle would have done
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    commit    = 1'b0;
    ctr_new   = ctr_step(cnt[w_hash], w_taken);
    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty) begin
                   pop       = 1'b1;
                   state_nxt = EVAL;
                 end
        EVAL:    state_nxt = (w_taken && ctr_new >= 2'd2) ? COMMIT : IDLE;
        COMMIT:  begin
                   commit    = 1'b1;
                   state_nxt = IDLE;
                 end
        FLUSH:   if (&sweep_idx) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Work registers, counter/valid tables and the flush sweep index
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= '0;
      valid     <= '0;
      w_hash    <= '0;
      w_tag     <= '0;
      w_target  <= '0;
      w_taken   <= 1'b0;
      sweep_idx <= '0;
    end else if (flush) begin
      sweep_idx <= '0;
    end else begin
      case (state)
        IDLE:    if (pop) {w_hash, w_tag, w_target, w_taken} <= fifo_rdata;
        EVAL:    begin
                   cnt[w_hash] <= ctr_new;
                   if (!w_taken && ctr_new == 2'd0) valid[w_hash] <= 1'b0;
                 end
        COMMIT:  valid[w_hash] <= 1'b1;
        FLUSH:   begin
                   cnt[sweep_idx]   <= '0;
                   valid[sweep_idx] <= 1'b0;
                   sweep_idx        <= sweep_idx + 1'b1;
                 end
        default: ;
      endcase
    end
  end

`ifdef BTB_UPDATE_STATS_EN
  // Saturating activity counters; only RESET clears them
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stat_upd    <= '0;
      stat_commit <= '0;
    end else begin
      if (push && stat_upd != 16'hFFFF)      stat_upd    <= stat_upd + 16'd1;
      if (commit && stat_commit != 16'hFFFF) stat_commit <= stat_commit + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed table-driven bench for btb_update_ctrl
module tb_btb_update_ctrl;
  import btb_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, flush = 1'b0, found_raw = 1'b0;
  logic        upd_ready, found, commit;
  logic [5:0]  upd_hash = '0, upd_tag = '0, hash_r = '0, hash_w, tag_w;
  logic [31:0] upd_target = '0, dest_w;
`ifdef BTB_UPDATE_STATS_EN
  logic [15:0] stat_upd, stat_commit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  btb_update_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_hash   (upd_hash),
    .upd_tag    (upd_tag),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .flush      (flush),
    .hash_r     (hash_r),
    .found_raw  (found_raw),
    .found      (found),
    .hash_w     (hash_w),
    .tag_w      (tag_w),
    .dest_w     (dest_w),
    .commit     (commit)
`ifdef BTB_UPDATE_STATS_EN
    ,
    .stat_upd   (stat_upd),
    .stat_commit(stat_commit)
`endif
  );

  typedef struct {
    logic [5:0]  hash;
    logic [5:0]  tag;
    logic [31:0] target;
    logic        taken;
    logic        exp_commit;
    logic        exp_found;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one update from IDLE and check the commit window t+1..t+4
  task automatic send_update(input logic [5:0] h, input logic [5:0] tg, input logic [31:0] tgt,
                             input logic tk, input logic exp_c, input string name);
    @(negedge CLK);
    upd_valid = 1'b1; upd_hash = h; upd_tag = tg; upd_target = tgt; upd_taken = tk;
    chk({name, " ready"}, 32'(upd_ready), 32'd1);
    @(negedge CLK);
    upd_valid = 1'b0;
    @(negedge CLK);
    chk({name, " commit t+2"}, 32'(commit), 32'd0);
    @(negedge CLK);
    chk({name, " commit t+3"}, 32'(commit), 32'(exp_c));
    if (exp_c) begin
      chk({name, " hash_w"}, 32'(hash_w), 32'(h));
      chk({name, " tag_w"}, 32'(tag_w), 32'(tg));
      chk({name, " dest_w"}, dest_w, tgt);
    end
    @(negedge CLK);
    chk({name, " commit t+4"}, 32'(commit), 32'd0);
  endtask

  task automatic probe(input logic [5:0] h, input logic exp, input string name);
    hash_r = h; found_raw = 1'b1;
    #1;
    chk({name, " found"}, 32'(found), 32'(exp));
    found_raw = 1'b0;
  endtask

  // Called one cycle after flush was raised: 64 sweep cycles, then IDLE
  task automatic check_flush(input string name);
    int bad = 0;
    hash_r = 6'd30; found_raw = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (upd_ready !== 1'b0 || found !== 1'b0 || commit !== 1'b0) bad++;
      @(negedge CLK);
    end
    found_raw = 1'b0;
    chk({name, " sweep cycles"}, 32'(bad), 32'd0);
    chk({name, " ready after"}, 32'(upd_ready), 32'd1);
  endtask

  initial begin
    logic        exp_ready [11];
    logic [31:0] got_dest [$];
    int          sent;
    int          nfound;

    vecs[0]  = '{6'd5,  6'd3,  32'h100,      1'b1, 1'b0, 1'b0};
    vecs[1]  = '{6'd5,  6'd3,  32'h100,      1'b1, 1'b1, 1'b1};
    vecs[2]  = '{6'd5,  6'd3,  32'h100,      1'b0, 1'b0, 1'b1};
    vecs[3]  = '{6'd5,  6'd3,  32'h100,      1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'd5,  6'd3,  32'h100,      1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'd5,  6'd3,  32'h100,      1'b1, 1'b0, 1'b0};
    vecs[6]  = '{6'd5,  6'd3,  32'h104,      1'b1, 1'b1, 1'b1};
    vecs[7]  = '{6'd5,  6'd3,  32'h108,      1'b1, 1'b1, 1'b1};
    vecs[8]  = '{6'd5,  6'd3,  32'h10C,      1'b1, 1'b1, 1'b1};
    vecs[9]  = '{6'd5,  6'd3,  32'h10C,      1'b0, 1'b0, 1'b1};
    vecs[10] = '{6'd9,  6'd7,  32'hDEADBEEC, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{6'd9,  6'd7,  32'hDEADBEEC, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{6'd63, 6'd63, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{6'd63, 6'd63, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b1};
    exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values before any clock edge
    #1 RESET = 1'b1;
    #1;
    probe(6'd0, 1'b0, "reset");
    chk("reset ready", 32'(upd_ready), 32'd1);
    chk("reset commit", 32'(commit), 32'd0);
    chk("reset hash_w", 32'(hash_w), 32'd0);
    chk("reset tag_w", 32'(tag_w), 32'd0);
    chk("reset dest_w", dest_w, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Single updates with hand-computed counter outcomes
    for (int i = 0; i < 14; i++) begin
      send_update(vecs[i].hash, vecs[i].tag, vecs[i].target, vecs[i].taken,
                  vecs[i].exp_commit, $sformatf("vec%0d", i));
      probe(vecs[i].hash, vecs[i].exp_found, $sformatf("vec%0d", i));
    end
    probe(6'd5, 1'b1, "hash5 kept");
    probe(6'd9, 1'b1, "hash9 kept");

    // Eight back-to-back taken updates to a fresh entry: queue fills, order kept
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (commit) got_dest.push_back(dest_w);
      if (sent < 8) begin
        upd_valid = 1'b1; upd_hash = 6'd30; upd_tag = 6'(sent + 1);
        upd_target = 32'h3000 + 32'(sent * 4); upd_taken = 1'b1;
      end else begin
        upd_valid = 1'b0;
      end
      if (c < 11) chk($sformatf("b2b ready c%0d", c), 32'(upd_ready), 32'(exp_ready[c]));
      if (upd_valid && upd_ready) sent++;
    end
    upd_valid = 1'b0;
    chk("b2b accepted", 32'(sent), 32'd8);
    chk("b2b commits", 32'(got_dest.size()), 32'd7);
    for (int i = 0; i < got_dest.size() && i < 7; i++)
      chk($sformatf("b2b order %0d", i), got_dest[i], 32'h3000 + 32'((i + 1) * 4));

    // Flush raised in the commit cycle, with a push offered at the same time
    send_update(6'd40, 6'd2, 32'h400, 1'b1, 1'b0, "fl prime");
    @(negedge CLK);
    upd_valid = 1'b1; upd_hash = 6'd40; upd_tag = 6'd2; upd_target = 32'h404; upd_taken = 1'b1;
    @(negedge CLK);
    upd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    flush = 1'b1; upd_valid = 1'b1;
    #1;
    chk("flush commit gated", 32'(commit), 32'd0);
    @(negedge CLK);
    flush = 1'b0; upd_valid = 1'b0;
    check_flush("flush1");
    nfound = 0;
    for (int h = 0; h < 64; h++) begin
      hash_r = 6'(h); found_raw = 1'b1;
      #1;
      if (found) nfound++;
    end
    found_raw = 1'b0;
    chk("flush all invalid", 32'(nfound), 32'd0);
    send_update(6'd40, 6'd2, 32'h408, 1'b1, 1'b0, "post flush h40");
    send_update(6'd30, 6'd1, 32'h308, 1'b1, 1'b0, "post flush h30");

    // Second flush mid-sweep restarts the sweep at index 0
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    repeat (9) @(negedge CLK);
    flush = 1'b1; upd_valid = 1'b1; upd_hash = 6'd50; upd_taken = 1'b1;
    @(negedge CLK);
    flush = 1'b0; upd_valid = 1'b0;
    check_flush("flush restart");
    send_update(6'd50, 6'd4, 32'h500, 1'b1, 1'b0, "post restart h50");

    // Reset asserted mid-EVAL with two updates still queued
    send_update(6'd7, 6'd5, 32'h700, 1'b1, 1'b0, "rst prime1");
    send_update(6'd7, 6'd5, 32'h700, 1'b1, 1'b1, "rst prime2");
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      upd_valid = 1'b1; upd_hash = 6'd8; upd_tag = 6'(i + 1);
      upd_target = 32'h800 + 32'(i); upd_taken = 1'b1;
    end
    @(negedge CLK);
    upd_valid = 1'b0;
    #1 RESET = 1'b1;
    #1;
    chk("midrst ready", 32'(upd_ready), 32'd1);
    chk("midrst commit", 32'(commit), 32'd0);
    chk("midrst hash_w", 32'(hash_w), 32'd0);
    chk("midrst tag_w", 32'(tag_w), 32'd0);
    chk("midrst dest_w", dest_w, 32'd0);
    probe(6'd7, 1'b0, "midrst");
    @(negedge CLK);
    RESET = 1'b0;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (commit) sent++;
    end
    chk("midrst fifo empty", 32'(sent), 32'd0);

`ifdef BTB_UPDATE_STATS_EN
    send_update(6'd11, 6'd1, 32'h1100, 1'b1, 1'b0, "stat1");
    send_update(6'd11, 6'd1, 32'h1100, 1'b1, 1'b1, "stat2");
    send_update(6'd12, 6'd1, 32'h1200, 1'b1, 1'b0, "stat3");
    chk("stat_upd", 32'(stat_upd), 32'd3);
    chk("stat_commit", 32'(stat_commit), 32'd1);
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    repeat (66) @(negedge CLK);
    chk("stat_upd after flush", 32'(stat_upd), 32'd3);
    chk("stat_commit after flush", 32'(stat_commit), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
